fma16_tv_recorder: RTL and testbench

Captures fma16 transactions (operands, control, result, flags) and packs each one into the team's 76-bit test-vector record: x, y, z, ctrl, result, flags. Records are buffered in a small FIFO and streamed out as five 16-bit beats, most-significant first, so a host can write a `.tv` file that the fma16 bench reads back. The block sits beside the fma16 datapath in the FPGA/emulation build, and is the writer for the test-vector reader.

---
 rtl/fma16_tv_pkg.sv | 32 +++
 rtl/fma16_tv_fifo.sv | 50 +++++
 rtl/fma16_tv_recorder.sv | 129 ++++++++++++
 tb/tb_fma16_tv_recorder.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fma16_tv_pkg.sv
// fma16_tv_pkg: shared types and helpers for the fma16 test-vector recorder.
// Record layout (76 bits, MSB first): x, y, z, ctrl, result, flags.
package fma16_tv_pkg;

   localparam int REC_W  = 76;
   localparam int BEAT_W = 16;
   localparam int NBEATS = 5;

   typedef struct packed {
      logic [15:0] x;
      logic [15:0] y;
      logic [15:0] z;
      logic [7:0]  ctrl;
      logic [15:0] result;
      logic [3:0]  flags;
   } tv_rec_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } ser_state_t;

   // Control byte as stored in the record: {2'b00, roundmode, mul, add, negp, negz}.
   function automatic logic [7:0] pack_ctrl(input logic [1:0] roundmode,
                                            input logic       mul,
                                            input logic       add,
                                            input logic       negp,
                                            input logic       negz);
      return {2'b00, roundmode, mul, add, negp, negz};
   endfunction

endpackage

// File: rtl/fma16_tv_fifo.sv
// fma16_tv_fifo: synchronous FIFO with extra-MSB pointers for full/empty
// detection. Writes are ignored when full, reads are ignored when empty.
module fma16_tv_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en_i,
   input  logic [W-1:0]  wr_data_i,
   input  logic          rd_en_i,
   output logic [W-1:0]  rd_data_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [AW:0]   count_o
);

   logic [W-1:0] mem_q [DEPTH];
   logic [AW:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]  rd_ptr_q, rd_ptr_d;
   logic         wr_fire, rd_fire;

   assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty_o   = (wr_ptr_q == rd_ptr_q);
   assign count_o   = wr_ptr_q - rd_ptr_q;
   assign wr_fire   = wr_en_i && !full_o;
   assign rd_fire   = rd_en_i && !empty_o;
   assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
   assign wr_ptr_d  = wr_ptr_q + (AW+1)'(wr_fire);
   assign rd_ptr_d  = rd_ptr_q + (AW+1)'(rd_fire);

   // Storage array: data only, not reset.
   always_ff @(posedge clk) begin
      if (wr_fire) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
   end

   // Pointer registers; they wrap naturally modulo 2*DEPTH.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

endmodule

// File: rtl/fma16_tv_recorder.sv
// fma16_tv_recorder: packs fma16 transactions into 76-bit test-vector records,
// buffers them, and streams each as five 16-bit beats (MSB first).
// Optional feature: define FMA16_TVREC_CNT_EN to add the rec_count output.
module fma16_tv_recorder
   import fma16_tv_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [15:0]       x,
   input  logic [15:0]       y,
   input  logic [15:0]       z,
   input  logic [1:0]        roundmode,
   input  logic              mul,
   input  logic              add,
   input  logic              negp,
   input  logic              negz,
   input  logic [15:0]       result,
   input  logic [3:0]        flags,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [BEAT_W-1:0] out_data,
   output logic              out_last
`ifdef FMA16_TVREC_CNT_EN
   ,
   output logic [31:0]       rec_count
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [2:0] LAST_BEAT = 3'(NBEATS - 1);

   tv_rec_t          rec_in;
   logic [REC_W-1:0] head_bits;
   logic [79:0]      word;
   logic             fifo_full, fifo_empty;
   logic [AW:0]      fifo_count;
   logic             push, hs, pop;
   ser_state_t       state_q;
   logic [2:0]       beat_idx_q;

   assign rec_in = '{x: x, y: y, z: z,
                     ctrl: pack_ctrl(roundmode, mul, add, negp, negz),
                     result: result, flags: flags};

   assign in_ready  = !fifo_full;
   assign out_valid = !fifo_empty;
   assign push      = in_valid && !fifo_full;
   assign hs        = out_valid && out_ready;
   assign pop       = hs && (beat_idx_q == LAST_BEAT);
   assign out_last  = out_valid && (beat_idx_q == LAST_BEAT);
   assign word      = {4'h0, head_bits};

   fma16_tv_fifo #(
      .W     (REC_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .wr_en_i   (push),
      .wr_data_i (rec_in),
      .rd_en_i   (pop),
      .rd_data_o (head_bits),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .count_o   (fifo_count)
   );

   // Beat mux: select the current 16-bit slice of the head record, zero when idle.
   always_comb begin
      out_data = '0;
      if (out_valid) begin
         case (beat_idx_q)
            3'd0:    out_data = word[79:64];
            3'd1:    out_data = word[63:48];
            3'd2:    out_data = word[47:32];
            3'd3:    out_data = word[31:16];
            3'd4:    out_data = word[15:0];
            default: out_data = '0;
         endcase
      end
   end

   // Serializer FSM: tracks beat position and whether any record is in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         beat_idx_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               beat_idx_q <= '0;
               if (push) state_q <= ST_SEND;
            end
            ST_SEND: begin
               if (hs) begin
                  if (beat_idx_q == LAST_BEAT) begin
                     beat_idx_q <= '0;
                     if (fifo_count == (AW+1)'(1) && !push) state_q <= ST_IDLE;
                  end else begin
                     beat_idx_q <= beat_idx_q + 3'd1;
                  end
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               beat_idx_q <= '0;
            end
         endcase
      end
   end

`ifdef FMA16_TVREC_CNT_EN
   logic [31:0] rec_count_q, rec_count_d;

   assign rec_count_d = rec_count_q + 32'(pop);
   assign rec_count   = rec_count_q;

   // Completed-record counter, advanced on each last-beat handshake.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) rec_count_q <= '0;
      else       rec_count_q <= rec_count_d;
   end
`endif

endmodule

// File: tb/tb_fma16_tv_recorder.sv
// tb_fma16_tv_recorder: randomized and directed bench with a queue-based
// reference model of the record stream.
module tb_fma16_tv_recorder;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] x = '0, y = '0, z = '0, result = '0;
   logic [1:0]  roundmode = '0;
   logic        mul = 1'b0, add = 1'b0, negp = 1'b0, negz = 1'b0;
   logic [3:0]  flags = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_data;
   logic        out_last;
`ifdef FMA16_TVREC_CNT_EN
   logic [31:0] rec_count;
`endif

   fma16_tv_recorder #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .y         (y),
      .z         (z),
      .roundmode (roundmode),
      .mul       (mul),
      .add       (add),
      .negp      (negp),
      .negz      (negz),
      .result    (result),
      .flags     (flags),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last)
`ifdef FMA16_TVREC_CNT_EN
      ,
      .rec_count (rec_count)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: queue of 80-bit beat words, position in head record, count.
   logic [79:0] mq [$];
   int          mbeat = 0;
   logic [31:0] mcnt  = '0;
   logic [16:0] acc_q [$];   // accepted beats {last, data}

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [79:0] make_word();
      return {4'h0, x, y, z, 2'b00, roundmode, mul, add, negp, negz, result, flags};
   endfunction

   function automatic logic [15:0] beat_of(input logic [79:0] w, input int k);
      logic [79:0] s;
      s = w >> (16 * (4 - k));
      return s[15:0];
   endfunction

   // Model update at each active edge (or on reset assertion).
   int          m_sz;
   logic        m_push;
   logic [79:0] m_new;
   initial forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
         mq.delete();
         mbeat = 0;
         mcnt  = '0;
      end else begin
         m_sz   = mq.size();
         m_push = in_valid && (m_sz < DEPTH);
         m_new  = make_word();
         if (m_sz > 0 && out_ready) begin
            if (mbeat == 4) begin
               void'(mq.pop_front());
               mbeat = 0;
               mcnt  = mcnt + 1;
            end else begin
               mbeat = mbeat + 1;
            end
         end
         if (m_push) mq.push_back(m_new);
      end
   end

   // Compare process and beat monitor on the inactive edge.
   initial forever begin
      @(negedge clk);
      chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
      chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
         chk("out_data", 32'(out_data), 32'(beat_of(mq[0], mbeat)));
         chk("out_last", 32'(out_last), 32'(mbeat == 4));
      end else begin
         chk("out_last_idle", 32'(out_last), 32'd0);
      end
`ifdef FMA16_TVREC_CNT_EN
      chk("rec_count", rec_count, mcnt);
`endif
      if (out_valid && out_ready) acc_q.push_back({out_last, out_data});
   end

   task automatic set_fields(input logic [15:0] ix, iy, iz, input logic [1:0] rm,
                             input logic m, a, np, nz, input logic [15:0] r,
                             input logic [3:0] f);
      x = ix; y = iy; z = iz; roundmode = rm;
      mul = m; add = a; negp = np; negz = nz; result = r; flags = f;
   endtask

   // Called at posedge+1; returns at posedge+1 after the capturing edge.
   task automatic push_rec(input logic [15:0] ix, iy, iz, input logic [1:0] rm,
                           input logic m, a, np, nz, input logic [15:0] r,
                           input logic [3:0] f);
      logic ok;
      int   n;
      ok = 1'b0;
      n  = 0;
      set_fields(ix, iy, iz, rm, m, a, np, nz, r, f);
      in_valid = 1'b1;
      while (!ok && n < 200) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0;
      if (!ok) chk("push_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_acc(input int n);
      int c;
      c = 0;
      while (acc_q.size() < n && c < 1000) begin
         @(posedge clk);
         c++;
      end
      #1;
      if (acc_q.size() < n) chk("beat_timeout", 32'(acc_q.size()), 32'(n));
   endtask

   task automatic chk_rec(input int base, input logic [15:0] b0, b1, b2, b3, b4);
      logic [15:0] e [5];
      e[0] = b0; e[1] = b1; e[2] = b2; e[3] = b3; e[4] = b4;
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("beat%0d_data", k), 32'(acc_q[base+k][15:0]), 32'(e[k]));
         chk($sformatf("beat%0d_last", k), 32'(acc_q[base+k][16]), 32'(k == 4));
      end
   endtask

   initial begin
      int c;
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
`ifdef FMA16_TVREC_CNT_EN
      chk("rst_rec_count", rec_count, 32'd0);
`endif
      reset = 1'b0;
      @(posedge clk); #1;

      // Basic record
      acc_q.delete();
      out_ready = 1'b1;
      push_rec(16'h3C00, 16'h4000, 16'h0000, 2'b01, 1, 0, 0, 0, 16'h4000, 4'h0);
      wait_acc(5);
      chk_rec(0, 16'h03C0, 16'h0400, 16'h0000, 16'h0184, 16'h0000);
`ifdef FMA16_TVREC_CNT_EN
      chk("basic_rec_count", rec_count, 32'd1);
`endif

      // Backpressure
      acc_q.delete();
      out_ready = 1'b0;
      push_rec(16'h3C00, 16'h4000, 16'h0000, 2'b01, 1, 0, 0, 0, 16'h4000, 4'h0);
      c = 0;
      while (!out_valid && c < 50) begin @(posedge clk); #1; c++; end
      chk("bp_valid", 32'(out_valid), 32'd1);
      repeat (10) begin
         @(negedge clk);
         chk("bp_hold", 32'(out_data), 32'h03C0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_acc(5);
      chk_rec(0, 16'h03C0, 16'h0400, 16'h0000, 16'h0184, 16'h0000);

      // Fill
      acc_q.delete();
      out_ready = 1'b0;
      for (int i = 1; i <= 4; i++)
         push_rec(16'(i), 16'h0000, 16'h0000, 2'b00, 0, 0, 0, 0, 16'h0000, 4'h0);
      chk("fill_in_ready", 32'(in_ready), 32'd0);
      set_fields(16'h0005, 16'h0, 16'h0, 2'b00, 0, 0, 0, 0, 16'h0, 4'h0);
      in_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      wait_acc(20);
      repeat (10) @(posedge clk);
      #1;
      chk("fill_count", 32'(acc_q.size()), 32'd20);
      for (int i = 0; i < 4; i++) begin
         chk("fill_b0", 32'(acc_q[5*i][15:0]), 32'h0000);
         chk("fill_b1", 32'(acc_q[5*i+1][15:0]), 32'((i + 1) << 12));
      end

      // Simultaneous push and pop
      acc_q.delete();
      out_ready = 1'b0;
      push_rec(16'h1230, 16'h0, 16'h0, 2'b00, 0, 0, 0, 0, 16'h0, 4'h0);
      push_rec(16'h4560, 16'h0, 16'h0, 2'b00, 0, 0, 0, 0, 16'h0, 4'h0);
      out_ready = 1'b1;
      c = 0;
      do begin @(negedge clk); c++; end while (!out_last && c < 50);
      chk("sim_last", 32'(out_last), 32'd1);
      chk("sim_in_ready", 32'(in_ready), 32'd1);
      set_fields(16'h7890, 16'h0, 16'h0, 2'b00, 0, 0, 0, 0, 16'h0, 4'h0);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_acc(15);
      repeat (8) @(posedge clk);
      #1;
      chk("sim_count", 32'(acc_q.size()), 32'd15);
      chk("sim_r0", 32'(acc_q[0][15:0]), 32'h0123);
      chk("sim_r1", 32'(acc_q[5][15:0]), 32'h0456);
      chk("sim_r2", 32'(acc_q[10][15:0]), 32'h0789);

      // Reset mid-record
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++)
         push_rec(16'hABC0 + 16'(i), 16'h1111, 16'h2222, 2'b10, 1, 1, 0, 0, 16'h3333, 4'h5);
      acc_q.delete();
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("mid_beats", 32'(acc_q.size()), 32'd3);
      reset = 1'b1;
      #1;
      chk("mid_out_valid", 32'(out_valid), 32'd0);
      chk("mid_out_data", 32'(out_data), 32'd0);
      chk("mid_in_ready", 32'(in_ready), 32'd1);
`ifdef FMA16_TVREC_CNT_EN
      chk("mid_rec_count", rec_count, 32'd0);
`endif
      @(posedge clk); #1;
      reset = 1'b0;
      acc_q.delete();
      out_ready = 1'b1;
      push_rec(16'h3C00, 16'h4000, 16'h0000, 2'b01, 1, 0, 0, 0, 16'h4000, 4'h0);
      wait_acc(5);
      chk_rec(0, 16'h03C0, 16'h0400, 16'h0000, 16'h0184, 16'h0000);

      // Flags/ctrl packing
      acc_q.delete();
      push_rec(16'h0000, 16'h0000, 16'h0000, 2'b11, 0, 1, 1, 1, 16'hFFFF, 4'hF);
      wait_acc(5);
      chk_rec(0, 16'h0000, 16'h0000, 16'h0000, 16'h037F, 16'hFFFF);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         set_fields(16'($urandom), 16'($urandom), 16'($urandom), 2'($urandom),
                    1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    16'($urandom), 4'($urandom));
         in_valid  = ($urandom_range(0, 2) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      chk("drain_empty", 32'(out_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
